// File: rtl/instr_fetcher.sv
// ============================================================================
// instr_fetcher : PC owner, I-cache lookup, miss refill and JAL prediction
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        icache_req_enable,
  output logic [31:0] icache_req_addr,
  input  logic        icache_hit_in,
  input  logic [31:0] icache_instr_in,
  output logic        icache_fill_enable,
  output logic [31:0] icache_fill_addr,
  output logic [31:0] icache_fill_instr,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_done_in,
  input  logic [31:0] mem_instr_in,
  input  logic        iq_full_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic [31:0] instr_pred_pc_out
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_req_addr;
  logic        r_fill_en;
  logic [31:0] r_fill_addr;
  logic [31:0] r_fill_instr;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_pred_pc;

  logic        w_req_en;
  logic [31:0] w_hit_npc;
  logic [31:0] w_mem_npc;
  logic [31:0] w_buf_npc;

  // JAL is predicted taken; everything else falls through.
  function automatic logic [31:0] f_next_pc(input logic [31:0] i, input logic [31:0] p);
    if (i[6:0] == 7'b1101111)
      return p + {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return p + 32'd4;
  endfunction

  assign w_req_en  = (r_state == S_FETCH) && !iq_full_in && !flush_in;
  assign w_hit_npc = f_next_pc(icache_instr_in, r_pc);
  assign w_mem_npc = f_next_pc(mem_instr_in, r_pc);
  assign w_buf_npc = f_next_pc(r_buf, r_pc);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_PC;
      r_buf           <= 32'h0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= 32'h0;
      r_fill_en       <= 1'b0;
      r_fill_addr     <= 32'h0;
      r_fill_instr    <= 32'h0;
      r_valid         <= 1'b0;
      r_instr         <= 32'h0;
      r_instr_pc      <= 32'h0;
      r_pred_pc       <= 32'h0;
    end else begin
      // Pulses drop every cycle, including frozen ones, so they never stretch.
      r_valid   <= 1'b0;
      r_fill_en <= 1'b0;
      if (rdy_in) begin
        if (flush_in) begin
          r_pc            <= flush_pc_in;
          r_state         <= S_FETCH;
          r_mem_req_valid <= 1'b0;
          if (r_mem_req_valid && mem_done_in) begin
            r_fill_en    <= 1'b1;
            r_fill_addr  <= r_pc;
            r_fill_instr <= mem_instr_in;
          end
        end else begin
          case (r_state)
            S_FETCH: begin
              if (w_req_en) begin
                if (icache_hit_in) begin
                  r_valid    <= 1'b1;
                  r_instr    <= icache_instr_in;
                  r_instr_pc <= r_pc;
                  r_pred_pc  <= w_hit_npc;
                  r_pc       <= w_hit_npc;
                end else begin
                  r_mem_req_valid <= 1'b1;
                  r_mem_req_addr  <= r_pc;
                  r_state         <= S_MISS;
                end
              end
            end
            S_MISS: begin
              if (mem_done_in) begin
                r_mem_req_valid <= 1'b0;
                r_fill_en       <= 1'b1;
                r_fill_addr     <= r_pc;
                r_fill_instr    <= mem_instr_in;
                r_buf           <= mem_instr_in;
                if (!iq_full_in) begin
                  r_valid    <= 1'b1;
                  r_instr    <= mem_instr_in;
                  r_instr_pc <= r_pc;
                  r_pred_pc  <= w_mem_npc;
                  r_pc       <= w_mem_npc;
                  r_state    <= S_FETCH;
                end else begin
                  r_state <= S_HOLD;
                end
              end
            end
            S_HOLD: begin
              if (!iq_full_in) begin
                r_valid    <= 1'b1;
                r_instr    <= r_buf;
                r_instr_pc <= r_pc;
                r_pred_pc  <= w_buf_npc;
                r_pc       <= w_buf_npc;
                r_state    <= S_FETCH;
              end
            end
            default: r_state <= S_FETCH;
          endcase
        end
      end
    end
  end

  assign icache_req_enable  = w_req_en;
  assign icache_req_addr    = r_pc;
  assign icache_fill_enable = r_fill_en;
  assign icache_fill_addr   = r_fill_addr;
  assign icache_fill_instr  = r_fill_instr;
  assign mem_req_valid      = r_mem_req_valid;
  assign mem_req_addr       = r_mem_req_addr;
  assign instr_valid_out    = r_valid;
  assign instr_out          = r_instr;
  assign instr_pc_out       = r_instr_pc;
  assign instr_pred_pc_out  = r_pred_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetcher.sv
// ============================================================================
// tb_instr_fetcher : scoreboard bench for instr_fetcher
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic [31:0] flush_pc_in;
  logic        icache_req_enable;
  logic [31:0] icache_req_addr;
  logic        icache_hit_in;
  logic [31:0] icache_instr_in;
  logic        icache_fill_enable;
  logic [31:0] icache_fill_addr, icache_fill_instr;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_done_in;
  logic [31:0] mem_instr_in;
  logic        iq_full_in;
  logic        instr_valid_out;
  logic [31:0] instr_out, instr_pc_out, instr_pred_pc_out;

  instr_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush_in(flush_in), .flush_pc_in(flush_pc_in),
    .icache_req_enable(icache_req_enable), .icache_req_addr(icache_req_addr),
    .icache_hit_in(icache_hit_in), .icache_instr_in(icache_instr_in),
    .icache_fill_enable(icache_fill_enable), .icache_fill_addr(icache_fill_addr),
    .icache_fill_instr(icache_fill_instr),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_done_in(mem_done_in), .mem_instr_in(mem_instr_in),
    .iq_full_in(iq_full_in),
    .instr_valid_out(instr_valid_out), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out), .instr_pred_pc_out(instr_pred_pc_out)
  );

  always #5 clk_in = ~clk_in;

  // Fixed cache contents; anything else misses.
  always_comb begin
    icache_hit_in   = 1'b1;
    icache_instr_in = 32'h0;
    case (icache_req_addr)
      32'h000: icache_instr_in = 32'h00100093;
      32'h004: icache_instr_in = 32'h00200113;
      32'h008: icache_instr_in = 32'h00300193;
      32'h200: icache_instr_in = 32'h0080006F;
      32'h208: icache_instr_in = 32'h00400213;
      32'h20C: icache_instr_in = 32'h00500293;
      32'h210: icache_instr_in = 32'hFF9FF06F;
      default: icache_hit_in   = 1'b0;
    endcase
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pred;
  } dlv_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fill_t;

  dlv_t  dlv_q[$];
  fill_t fill_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic exp_dlv(input logic [31:0] i, input logic [31:0] p, input logic [31:0] n);
    dlv_t d;
    d.instr = i; d.pc = p; d.pred = n;
    dlv_q.push_back(d);
  endtask

  task automatic exp_fill(input logic [31:0] a, input logic [31:0] d);
    fill_t f;
    f.addr = a; f.data = d;
    fill_q.push_back(f);
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush_in    = 1'b1;
    flush_pc_in = target;
    tick();
    flush_in    = 1'b0;
  endtask

  // Monitor: every pulse must match the head of its queue; unexpected pulses fail.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (instr_valid_out) begin
        dlv_t d;
        if (dlv_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", instr_pc_out, instr_out);
        end else begin
          d = dlv_q.pop_front();
          chk("dlv_instr", instr_out, d.instr);
          chk("dlv_pc", instr_pc_out, d.pc);
          chk("dlv_pred", instr_pred_pc_out, d.pred);
        end
      end
      if (icache_fill_enable) begin
        fill_t f;
        if (fill_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_fill: got addr %h data %h expected none", icache_fill_addr, icache_fill_instr);
        end else begin
          f = fill_q.pop_front();
          chk("fill_addr", icache_fill_addr, f.addr);
          chk("fill_data", icache_fill_instr, f.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc_in = 32'h0;
    mem_done_in = 1'b0; mem_instr_in = 32'h0; iq_full_in = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {31'h0, instr_valid_out}, 32'h0);
    chk("rst_fill", {31'h0, icache_fill_enable}, 32'h0);
    chk("rst_memreq", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_memaddr", mem_req_addr, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc_out", instr_pc_out, 32'h0);
    chk("rst_pred", instr_pred_pc_out, 32'h0);
    chk("rst_reqaddr", icache_req_addr, 32'h0);

    // Back-to-back hits at 0, 4, 8.
    rst_in = 1'b0;
    exp_dlv(32'h00100093, 32'h000, 32'h004);
    exp_dlv(32'h00200113, 32'h004, 32'h008);
    exp_dlv(32'h00300193, 32'h008, 32'h00C);
    iq_full_in = 1'b0;
    repeat (3) tick();
    iq_full_in = 1'b1;
    chk("hits_reqaddr", icache_req_addr, 32'h00C);

    // Miss at 0x100, completion after 5 cycles, delivered immediately.
    do_flush(32'h100);
    iq_full_in = 1'b0;
    tick();
    chk("miss_memreq", {31'h0, mem_req_valid}, 32'h1);
    chk("miss_memaddr", mem_req_addr, 32'h100);
    repeat (4) begin
      tick();
      chk("miss_hold_memreq", {31'h0, mem_req_valid}, 32'h1);
    end
    mem_done_in = 1'b1; mem_instr_in = 32'h00000013;
    exp_fill(32'h100, 32'h00000013);
    exp_dlv(32'h00000013, 32'h100, 32'h104);
    tick();
    mem_done_in = 1'b0; iq_full_in = 1'b1;
    chk("miss_done_memreq", {31'h0, mem_req_valid}, 32'h0);
    chk("miss_next_reqaddr", icache_req_addr, 32'h104);

    // JAL +8 at 0x200, then JAL -8 at 0x210.
    do_flush(32'h200);
    exp_dlv(32'h0080006F, 32'h200, 32'h208);
    iq_full_in = 1'b0;
    tick();
    iq_full_in = 1'b1;
    chk("jal_pos_reqaddr", icache_req_addr, 32'h208);
    exp_dlv(32'h00400213, 32'h208, 32'h20C);
    exp_dlv(32'h00500293, 32'h20C, 32'h210);
    exp_dlv(32'hFF9FF06F, 32'h210, 32'h208);
    iq_full_in = 1'b0;
    repeat (3) tick();
    iq_full_in = 1'b1;
    chk("jal_neg_reqaddr", icache_req_addr, 32'h208);

    // Flush coinciding with mem_done: fill only, then stray done ignored.
    do_flush(32'h300);
    iq_full_in = 1'b0;
    tick();
    iq_full_in = 1'b1;
    chk("fl_memreq", {31'h0, mem_req_valid}, 32'h1);
    chk("fl_memaddr", mem_req_addr, 32'h300);
    repeat (2) tick();
    flush_in = 1'b1; flush_pc_in = 32'h400;
    mem_done_in = 1'b1; mem_instr_in = 32'hDEADBEEF;
    exp_fill(32'h300, 32'hDEADBEEF);
    tick();
    flush_in = 1'b0; mem_done_in = 1'b0;
    chk("fl_memreq_drop", {31'h0, mem_req_valid}, 32'h0);
    chk("fl_reqaddr", icache_req_addr, 32'h400);
    mem_done_in = 1'b1; mem_instr_in = 32'h12345678;
    tick();
    mem_done_in = 1'b0;
    tick();
    chk("stray_memreq", {31'h0, mem_req_valid}, 32'h0);
    chk("stray_reqaddr", icache_req_addr, 32'h400);

    // HOLD: queue full at completion, release after 3 cycles.
    do_flush(32'h500);
    iq_full_in = 1'b0;
    tick();
    iq_full_in = 1'b1;
    repeat (2) tick();
    mem_done_in = 1'b1; mem_instr_in = 32'h00500093;
    exp_fill(32'h500, 32'h00500093);
    tick();
    mem_done_in = 1'b0;
    chk("hold_memreq", {31'h0, mem_req_valid}, 32'h0);
    repeat (3) tick();
    chk("hold_reqaddr", icache_req_addr, 32'h500);
    exp_dlv(32'h00500093, 32'h500, 32'h504);
    iq_full_in = 1'b0;
    tick();
    iq_full_in = 1'b1;
    chk("hold_next_reqaddr", icache_req_addr, 32'h504);

    // rdy_in low mid-MISS: everything frozen, even with mem_done present.
    do_flush(32'h600);
    iq_full_in = 1'b0;
    tick();
    rdy_in = 1'b0;
    mem_done_in = 1'b1; mem_instr_in = 32'hCAFEF00D;
    repeat (4) begin
      tick();
      mem_done_in = 1'b0;
      chk("frz_memreq", {31'h0, mem_req_valid}, 32'h1);
      chk("frz_memaddr", mem_req_addr, 32'h600);
      chk("frz_reqaddr", icache_req_addr, 32'h600);
    end
    rdy_in = 1'b1;
    mem_done_in = 1'b1; mem_instr_in = 32'h00600313;
    exp_fill(32'h600, 32'h00600313);
    exp_dlv(32'h00600313, 32'h600, 32'h604);
    tick();
    mem_done_in = 1'b0; iq_full_in = 1'b1;
    chk("frz_done_memreq", {31'h0, mem_req_valid}, 32'h0);
    chk("frz_next_reqaddr", icache_req_addr, 32'h604);

    repeat (3) tick();
    chk("dlv_queue_empty", dlv_q.size(), 32'h0);
    chk("fill_queue_empty", fill_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Front-end fetch stage of the RISC-V core. Owns the PC and looks each PC up in the instruction cache.
- On a cache miss it requests the word from the memory controller, refills the cache and forwards the word to the decoder's instruction queue.
- Static prediction: JAL is taken; every other instruction falls through to PC+4.
- Redirects from the ROB (flush) override everything.

Parameters:
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; 0 freezes all state
flush_in  input  1  redirect request from ROB
flush_pc_in  input  32  redirect target
icache_req_enable  output  1  lookup request (combinational)
icache_req_addr  output  32  lookup address = pc (combinational)
icache_hit_in  input  1  same-cycle hit from cache
icache_instr_in  input  32  same-cycle cached word
icache_fill_enable  output  1  one-cycle cache write pulse
icache_fill_addr  output  32  fill address
icache_fill_instr  output  32  fill data
mem_req_valid  output  1  memory fetch request, level-held until done
mem_req_addr  output  32  word address requested
mem_done_in  input  1  one-cycle completion from memory controller
mem_instr_in  input  32  fetched word, valid with mem_done_in
iq_full_in  input  1  instruction queue cannot accept next cycle
instr_valid_out  output  1  one-cycle delivery pulse
instr_out  output  32  delivered instruction
instr_pc_out  output  32  PC of delivered instruction
instr_pred_pc_out  output  32  predicted next PC

Behaviour:
- Reset:
  - pc=RESET_PC; state=FETCH.
  - All outputs 0, except combinational icache_req_addr=pc.
- rdy_in=0: every register holds; delivery and fill pulses are not regenerated. Reset takes priority over rdy_in.
- next_pc(i,p):
  - If i[6:0]==7'b1101111: p + {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}, mod 2^32.
  - Otherwise: p+4, wrapping at 2^32.
- Registered pulses: instr_valid_out and icache_fill_enable default to 0 every cycle and are high for exactly one cycle per event.
- FETCH:
  - icache_req_enable = !iq_full_in && !flush_in.
  - iq_full_in=1: hold.
  - Hit:
    - Next cycle: instr_valid_out=1, instr_out=icache_instr_in, instr_pc_out=pc, instr_pred_pc_out=next_pc.
    - pc<=next_pc; stay in FETCH. Sustained throughput is 1 instruction/cycle.
  - Miss: mem_req_valid<=1, mem_req_addr<=pc; go to MISS.
- MISS:
  - mem_req_valid stays 1 until mem_done_in.
  - On mem_done_in:
    - mem_req_valid<=0.
    - Fill pulse next cycle with addr=pc, data=mem_instr_in.
    - Latch the word in the fetch buffer.
    - If !iq_full_in: deliver next cycle as for a hit, pc<=next_pc, go to FETCH.
    - Else go to HOLD.
- HOLD: when iq_full_in drops, deliver the buffered word next cycle, pc<=next_pc, go to FETCH.
- Flush (flush_in=1 while rdy_in, any state; highest priority after reset):
  - pc<=flush_pc_in; state<=FETCH; mem_req_valid<=0; no delivery next cycle; fetch buffer discarded.
  - If flush_in and mem_done_in coincide, the fill is still issued but the word is not delivered.
  - mem_done_in arriving while mem_req_valid=0 is ignored. Deassertion of mem_req_valid is defined as a request cancel to the memory controller.
- Delivery ordering: strictly program order along the predicted path. No instruction is delivered twice or skipped except by flush.
- Misaligned PCs are not checked; pc[1:0] passes through to the address outputs.

Test Plan:
- Reset with RESET_PC=0, cache hits at 0,4,8 -> pulses at cycles 1,2,3 with instr_pc_out 0,4,8 and pred_pc 4,8,12.
- Miss at 0x100; mem_done after 5 cycles with 32'h00000013 -> mem_req_valid high until done. Next cycle: fill pulse (0x100, 0x13), delivery with pc 0x100, pred 0x104.
- JAL 32'h0080006F hit at 0x200 -> pred_pc 0x208; next lookup address 0x208.
- JAL with negative offset 32'hFF9FF06F at 0x210 -> pred_pc 0x208 (offset -8).
- Flush to 0x400 during MISS, with mem_done in the same cycle -> fill issued, no delivery, next lookup 0x400. A later stray mem_done is ignored.
- iq_full_in high when mem_done arrives -> HOLD. Release after 3 cycles -> single delivery the cycle after release.
- rdy_in low for 4 cycles mid-MISS -> pc, state and mem_req_valid unchanged, no pulses.
